// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
//
// Multi-cycle execution stage of the calculator datapath. It takes the two
// operands read from the 3-entry register bank and an operation code. It
// computes the result and then drives the bank write port so the result is
// stored into the accumulator register.
//
// Logic ops finish in one CALC cycle. Multiply uses iterative shift-add.
// Divide and modulo use iterative restoring division (one bit per clock).
//
// Ports
//   Clock      in   system clock, all state updates on the rising edge
//   Reset      in   synchronous, active-high reset
//   Inicio     in   start request, accepted only when the unit is free
//   Operacao   in   3-bit op code (add, sub, and, or, mul, div, mod, invalid)
//   OperandoA  in   first operand (bank DadoLido1)
//   OperandoB  in   second operand (bank DadoLido2)
//   Ocupado    out  high while an operation is in CALC or ESCREVE
//   Pronto     out  one-cycle completion pulse
//   Resultado  out  result, drives the bank Dado input
//   Escrita    out  bank write enable, one-cycle pulse, low on error
//   IdReg      out  bank write index, fixed to ID_DESTINO
//   Erro       out  division by zero or invalid op, valid with Pronto
// ---------------------------------------------------------------------------
module ula_multiciclo #(
   parameter int         WIDTH      = 32,
   parameter logic [1:0] ID_DESTINO = 2'b10
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Inicio,
   input  logic [2:0]       Operacao,
   input  logic [WIDTH-1:0] OperandoA,
   input  logic [WIDTH-1:0] OperandoB,
   output logic             Ocupado,
   output logic             Pronto,
   output logic [WIDTH-1:0] Resultado,
   output logic             Escrita,
   output logic [1:0]       IdReg,
   output logic             Erro
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;
   localparam logic [2:0] OP_MOD = 3'b110;

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      CALC    = 2'b01,
      ESCREVE = 2'b10
   } estado_t;

   estado_t          r_estado;
   logic [CW-1:0]    r_cont;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_aux;
   logic [WIDTH-1:0] r_opB;
   logic [WIDTH-1:0] r_resultado;
   logic             r_erro;

   logic [WIDTH-1:0] w_logica;
   logic [WIDTH-1:0] w_prodNext;
   logic [WIDTH:0]   w_remShift;
   logic [WIDTH:0]   w_trial;
   logic             w_cabe;
   logic [WIDTH-1:0] w_remNext;
   logic [WIDTH-1:0] w_quoNext;
   logic             w_divZero;
   logic             w_ultimo;

   // Single-cycle results. r_aux still holds OperandoA during the first
   // CALC cycle, and that is the only cycle in which these ops use it.
   always_comb begin
      w_logica = '0;
      case (r_op)
         OP_ADD:  w_logica = r_aux + r_opB;
         OP_SUB:  w_logica = r_aux - r_opB;
         OP_AND:  w_logica = r_aux & r_opB;
         OP_OR:   w_logica = r_aux | r_opB;
         default: w_logica = '0;
      endcase
   end

   // Shift-add multiply step.
   // r_aux is the multiplicand, shifted left once per cycle.
   // r_opB is the multiplier, shifted right once per cycle.
   // Bits above WIDTH are dropped, so the product is truncated.
   assign w_prodNext = r_acc + (r_opB[0] ? r_aux : '0);

   // Restoring division step.
   // r_acc is the partial remainder.
   // r_aux shifts the dividend out at the top and the quotient bits in at
   // the bottom.
   // The trial subtraction is one bit wider than WIDTH, so its top bit acts
   // as the borrow flag.
   assign w_remShift = {r_acc, r_aux[WIDTH-1]};
   assign w_trial    = w_remShift - {1'b0, r_opB};
   assign w_cabe     = ~w_trial[WIDTH];
   assign w_remNext  = w_cabe ? w_trial[WIDTH-1:0] : w_remShift[WIDTH-1:0];
   assign w_quoNext  = {r_aux[WIDTH-2:0], w_cabe};

   assign w_divZero = (r_opB == '0);
   assign w_ultimo  = (r_cont == ULTIMO);

   // Main FSM, covering the datapath registers as well.
   // ESCREVE accepts a new Inicio on its closing edge. That gives the
   // documented back-to-back rate of one add every two cycles. The error
   // flag is cleared on the accepting edge, and Resultado keeps its value
   // until the next completion.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_estado    <= OCIOSO;
         r_cont      <= '0;
         r_op        <= '0;
         r_acc       <= '0;
         r_aux       <= '0;
         r_opB       <= '0;
         r_resultado <= '0;
         r_erro      <= 1'b0;
      end else begin
         case (r_estado)
            OCIOSO, ESCREVE: begin
               if (Inicio) begin
                  r_op     <= Operacao;
                  r_aux    <= OperandoA;
                  r_opB    <= OperandoB;
                  r_acc    <= '0;
                  r_cont   <= '0;
                  r_erro   <= 1'b0;
                  r_estado <= CALC;
               end else begin
                  r_estado <= OCIOSO;
               end
            end

            CALC: begin
               case (r_op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     r_resultado <= w_logica;
                     r_erro      <= 1'b0;
                     r_estado    <= ESCREVE;
                  end

                  OP_MUL: begin
                     r_acc  <= w_prodNext;
                     r_aux  <= r_aux << 1;
                     r_opB  <= r_opB >> 1;
                     r_cont <= r_cont + 1'b1;
                     if (w_ultimo) begin
                        r_resultado <= w_prodNext;
                        r_erro      <= 1'b0;
                        r_estado    <= ESCREVE;
                     end
                  end

                  OP_DIV, OP_MOD: begin
                     // The divisor never changes during the operation, so
                     // the zero test only ever fires on the first CALC
                     // cycle. At that point r_aux is still the dividend.
                     if (w_divZero) begin
                        r_resultado <= (r_op == OP_DIV) ? '1 : r_aux;
                        r_erro      <= 1'b1;
                        r_estado    <= ESCREVE;
                     end else begin
                        r_acc  <= w_remNext;
                        r_aux  <= w_quoNext;
                        r_cont <= r_cont + 1'b1;
                        if (w_ultimo) begin
                           r_resultado <= (r_op == OP_DIV) ? w_quoNext : w_remNext;
                           r_erro      <= 1'b0;
                           r_estado    <= ESCREVE;
                        end
                     end
                  end

                  default: begin
                     r_resultado <= '0;
                     r_erro      <= 1'b1;
                     r_estado    <= ESCREVE;
                  end
               endcase
            end

            default: r_estado <= OCIOSO;
         endcase
      end
   end

   // Handshake outputs are decoded only from registered state.
   // Escrita is high for the whole ESCREVE cycle, so the bank's
   // falling-edge write sees a stable Resultado.
   assign Ocupado   = (r_estado == CALC) || (r_estado == ESCREVE);
   assign Pronto    = (r_estado == ESCREVE);
   assign Escrita   = (r_estado == ESCREVE) && !r_erro;
   assign Resultado = r_resultado;
   assign Erro      = r_erro;
   assign IdReg     = ID_DESTINO;

endmodule

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo
//
// Directed vectors with hand-computed expected values.
//
// The stimulus side pushes each expected completion into a scoreboard queue.
// An independent monitor pops an entry and compares it every time the DUT
// raises Pronto.
// ---------------------------------------------------------------------------
module tb_ula_multiciclo;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;
   localparam logic [2:0] OP_MOD = 3'b110;
   localparam logic [2:0] OP_INV = 3'b111;

   logic             Clock;
   logic             Reset;
   logic             Inicio;
   logic [2:0]       Operacao;
   logic [WIDTH-1:0] OperandoA;
   logic [WIDTH-1:0] OperandoB;
   logic             Ocupado;
   logic             Pronto;
   logic [WIDTH-1:0] Resultado;
   logic             Escrita;
   logic [1:0]       IdReg;
   logic             Erro;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             erro;
      logic             escrita;
      int               doneCycle;
   } esperado_t;

   esperado_t sb[$];

   int assertions  = 0;
   int failures    = 0;
   int cycleCount  = 0;
   int prontoCount = 0;
   int issued      = 0;

   ula_multiciclo #(.WIDTH(WIDTH), .ID_DESTINO(2'b10)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Inicio    (Inicio),
      .Operacao  (Operacao),
      .OperandoA (OperandoA),
      .OperandoB (OperandoB),
      .Ocupado   (Ocupado),
      .Pronto    (Pronto),
      .Resultado (Resultado),
      .Escrita   (Escrita),
      .IdReg     (IdReg),
      .Erro      (Erro)
   );

   // Free-running clock with period 10
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Edge counter used to check completion latency
   always @(posedge Clock) cycleCount++;

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkOutput(input string nome, input logic [31:0] atual,
                              input logic [31:0] req);
      assertions++;
      if (atual !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nome, atual, req);
      end
   endtask

   // Issue one operation and record its expected completion
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expRes,
                                input logic expErro, input int latencia);
      esperado_t e;
      @(negedge Clock);
      Operacao  = op;
      OperandoA = a;
      OperandoB = b;
      Inicio    = 1'b1;
      @(posedge Clock);
      #1;
      e.res       = expRes;
      e.erro      = expErro;
      e.escrita   = ~expErro;
      e.doneCycle = cycleCount + latencia;
      sb.push_back(e);
      issued++;
      @(negedge Clock);
      Inicio = 1'b0;
   endtask

   // Wait, with a bound, until the monitor has consumed every expectation
   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge Clock);
         n++;
      end
      if (sb.size() != 0) begin
         assertions++;
         failures++;
         $display("[TB] FAIL timeout: %0d completions still pending, expected 0", sb.size());
         sb.delete();
      end
      @(negedge Clock);
   endtask

   // Monitor: every Pronto pulse must match the oldest expectation
   always @(negedge Clock) begin
      esperado_t e;
      if (Pronto === 1'b1) begin
         prontoCount++;
         if (sb.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL unexpected Pronto: got Resultado 0x%08h at cycle %0d, expected none",
                     Resultado, cycleCount);
         end else begin
            e = sb.pop_front();
            checkOutput("Resultado", Resultado, e.res);
            checkOutput("Erro", {31'b0, Erro}, {31'b0, e.erro});
            checkOutput("Escrita", {31'b0, Escrita}, {31'b0, e.escrita});
            checkOutput("IdReg", {30'b0, IdReg}, 32'h2);
            checkOutput("Ocupado at Pronto", {31'b0, Ocupado}, 32'h1);
            checkOutput("latency cycle", cycleCount, e.doneCycle);
         end
      end
   end

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time exceeded");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Reset     = 1'b1;
      Inicio    = 1'b0;
      Operacao  = '0;
      OperandoA = '0;
      OperandoB = '0;

      // Reset held for two edges, then released
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      checkOutput("reset Ocupado", {31'b0, Ocupado}, 32'h0);
      checkOutput("reset Pronto", {31'b0, Pronto}, 32'h0);
      checkOutput("reset Escrita", {31'b0, Escrita}, 32'h0);
      checkOutput("reset Erro", {31'b0, Erro}, 32'h0);
      checkOutput("reset Resultado", Resultado, 32'h0);

      // Reset in the middle of a multiply discards the operation
      Operacao  = OP_MUL;
      OperandoA = 32'd7;
      OperandoB = 32'd6;
      Inicio    = 1'b1;
      @(negedge Clock);
      Inicio = 1'b0;
      repeat (10) @(negedge Clock);
      checkOutput("busy mid mul", {31'b0, Ocupado}, 32'h1);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      checkOutput("abort Ocupado", {31'b0, Ocupado}, 32'h0);
      checkOutput("abort Resultado", Resultado, 32'h0);
      repeat (WIDTH + 4) @(negedge Clock);
      checkOutput("abort no Pronto", prontoCount, 32'd0);

      // Single-cycle ops
      applyStimulus(OP_ADD, 32'd5, 32'd9, 32'd14, 1'b0, 1);
      waitIdle(10);
      applyStimulus(OP_SUB, 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b0, 1);
      waitIdle(10);
      applyStimulus(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
      waitIdle(10);
      applyStimulus(OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
      waitIdle(10);
      applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1);
      waitIdle(10);

      // Multiply, including truncation cases
      applyStimulus(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, WIDTH);
      waitIdle(60);
      applyStimulus(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, WIDTH);
      waitIdle(60);
      applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, WIDTH);
      waitIdle(60);

      // Divide and modulo
      applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, WIDTH);
      waitIdle(60);
      applyStimulus(OP_MOD, 32'd100, 32'd7, 32'd2, 1'b0, WIDTH);
      waitIdle(60);
      applyStimulus(OP_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, WIDTH);
      waitIdle(60);
      applyStimulus(OP_MOD, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, WIDTH);
      waitIdle(60);

      // Error cases complete after one edge
      applyStimulus(OP_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
      waitIdle(10);
      applyStimulus(OP_MOD, 32'd100, 32'd0, 32'd100, 1'b1, 1);
      waitIdle(10);
      applyStimulus(OP_INV, 32'd3, 32'd4, 32'd0, 1'b1, 1);
      waitIdle(10);
      checkOutput("Erro held", {31'b0, Erro}, 32'h1);
      checkOutput("Resultado held", Resultado, 32'h0);

      // Inicio pulses during a multiply are ignored
      applyStimulus(OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, WIDTH);
      for (int i = 0; i < 10; i++) begin
         Operacao  = OP_ADD;
         OperandoA = 32'd1;
         OperandoB = 32'd1;
         Inicio    = 1'b1;
         @(negedge Clock);
         Inicio = 1'b0;
         @(negedge Clock);
      end
      waitIdle(60);

      // Inicio held high: an add is accepted every second edge, and the
      // operand present on that edge is the one latched
      Operacao  = OP_ADD;
      OperandoB = 32'd100;
      Inicio    = 1'b1;
      for (int j = 0; j < 5; j++) begin
         esperado_t e;
         OperandoA = 32'(j + 1);
         @(posedge Clock);
         #1;
         if ((j % 2) == 0) begin
            e.res       = 32'(j + 1 + 100);
            e.erro      = 1'b0;
            e.escrita   = 1'b1;
            e.doneCycle = cycleCount + 1;
            sb.push_back(e);
            issued++;
         end
         @(negedge Clock);
      end
      Inicio = 1'b0;
      waitIdle(20);

      repeat (3) @(negedge Clock);
      checkOutput("Pronto count", prontoCount, issued);
      checkOutput("final idle", {31'b0, Ocupado}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
